// File: rtl/srsc_gain_divider_if.sv
// -----------------------------------------------------------------------------
// srsc_gain_divider_if
// Operand/result handshake bundle for the saturation-correction gain divider.
//   in_valid / in_ready : operand pair handshake (num, den unsigned integers)
//   out_valid/ out_ready: result handshake (gain Q3.13, sat clamp flag)
// Modports:
//   master : the side that issues operands and consumes results
//   slave  : the divider itself
// -----------------------------------------------------------------------------
interface srsc_gain_divider_if #(
  parameter int IN_W = 8,
  parameter int Q_W  = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] num;
  logic [IN_W-1:0] den;
  logic            out_valid;
  logic            out_ready;
  logic [Q_W-1:0]  gain;
  logic            sat;

  modport master (
    output in_valid, num, den, out_ready,
    input  in_ready, out_valid, gain, sat
  );

  modport slave (
    input  in_valid, num, den, out_ready,
    output in_ready, out_valid, gain, sat
  );
endinterface

// File: rtl/srsc_gain_divider.sv
// -----------------------------------------------------------------------------
// srsc_gain_divider
// Sequential radix-2 restoring divider producing the per-pixel saturation
// correction gain = floor(num * 2^FRAC_BITS / den) in Q3.13, clamped to
// all-ones (with sat=1) when the quotient does not fit or den is zero.
// Fixed latency: accept in cycle t, result valid in cycle t+18.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   s_bus : operand/result handshake (slave modport of srsc_gain_divider_if)
// -----------------------------------------------------------------------------
module srsc_gain_divider #(
  parameter int IN_W      = 8,
  parameter int FRAC_BITS = 13,
  parameter int Q_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  srsc_gain_divider_if.slave   s_bus
);

  localparam int INT_BITS = Q_W - FRAC_BITS;
  localparam int CNT_W    = $clog2(Q_W);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t          r_state;
  logic [IN_W-1:0] r_num;
  logic [IN_W-1:0] r_den;
  logic [IN_W-1:0] r_rem;       // partial remainder, always < den between steps
  logic [Q_W-1:0]  r_dq;        // dividend bits shift out the top, quotient bits shift in the bottom
  logic [CNT_W-1:0] r_cnt;
  logic            r_sat_flag;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [Q_W-1:0]  r_gain;
  logic            r_sat;

  logic [IN_W:0]   w_rem_shift;
  logic            w_ge;
  logic [IN_W-1:0] w_rem_next;
  logic            w_sat_flag;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // The difference is < den when taken, so IN_W-bit modular subtraction is exact.
  assign w_rem_shift = {r_rem, r_dq[Q_W-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_den});
  assign w_rem_next  = w_ge ? (w_rem_shift[IN_W-1:0] - r_den) : w_rem_shift[IN_W-1:0];

  // Quotient overflows Q_W bits exactly when num/den >= 2^INT_BITS.
  assign w_sat_flag  = (r_den == '0) ||
                       ({{INT_BITS{1'b0}}, r_num} >= {r_den, {INT_BITS{1'b0}}});

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register is cleared here, datapath included, so an aborted
      // division leaves no stale operand or partial result behind.
      r_state     <= IDLE;
      r_num       <= '0;
      r_den       <= '0;
      r_rem       <= '0;
      r_dq        <= '0;
      r_cnt       <= '0;
      r_sat_flag  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_gain      <= '0;
      r_sat       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the values registers held before this edge.
      case (r_state)
        IDLE: begin
          if (s_bus.in_valid && r_in_ready) begin
            r_num      <= s_bus.num;
            r_den      <= s_bus.den;
            r_in_ready <= 1'b0;
            r_state    <= LOAD;
          end
        end

        LOAD: begin
          r_sat_flag <= w_sat_flag;
          // The dividend num<<FRAC_BITS has bits above Q_W-1. Those steps can
          // only yield quotient zeros when unsaturated, so their remainder is
          // simply the upper dividend bits; preload it and run Q_W steps over
          // the low Q_W dividend bits.
          r_rem      <= r_num >> INT_BITS;
          r_dq       <= Q_W'({r_num, {FRAC_BITS{1'b0}}});
          r_cnt      <= CNT_W'(Q_W - 1);
          r_state    <= DIV;
        end

        DIV: begin
          r_rem <= w_rem_next;
          r_dq  <= {r_dq[Q_W-2:0], w_ge};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_gain      <= r_sat_flag ? '1 : {r_dq[Q_W-2:0], w_ge};
            r_sat       <= r_sat_flag;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end

        DONE: begin
          // gain/sat stay as they are after the handshake.
          if (s_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_bus.in_ready  = r_in_ready;
  assign s_bus.out_valid = r_out_valid;
  assign s_bus.gain      = r_gain;
  assign s_bus.sat       = r_sat;

endmodule

// File: tb/tb_srsc_gain_divider.sv
// -----------------------------------------------------------------------------
// tb_srsc_gain_divider
// Directed and random checks of srsc_gain_divider: reset values, exact
// quotients, saturation boundary, zero operands, backpressure, back-to-back
// issue, reset mid-division, and a random run against a reference formula.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_srsc_gain_divider;

  typedef struct {
    logic [7:0]  n;
    logic [7:0]  d;
    logic [15:0] g;
    logic        s;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  srsc_gain_divider_if bus ();

  srsc_gain_divider dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issue one operand pair, wait for the result, hold out_ready low for
  // 'stall' cycles, then complete the handshake. lat = out_valid cycle - accept cycle.
  task automatic do_op(input logic [7:0] n, input logic [7:0] d, input int stall,
                       output logic [15:0] g, output logic s, output int lat,
                       output bit ok);
    int c0;
    ok  = 1'b0;
    lat = -1;
    g   = '0;
    s   = 1'b0;
    @(negedge clk);
    bus.out_ready = (stall == 0);
    for (int k = 0; k < 40 && !bus.in_ready; k++) @(negedge clk);
    if (bus.in_ready) begin
      bus.in_valid = 1'b1;
      bus.num = n;
      bus.den = d;
      c0 = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.num = 8'($urandom);
      bus.den = 8'($urandom);
      for (int k = 0; k < 40 && !bus.out_valid; k++) @(negedge clk);
      if (bus.out_valid) begin
        lat = cyc - c0;
        g = bus.gain;
        s = bus.sat;
        repeat (stall) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.num = '0;
    bus.den = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.gain !== 16'h0000) begin bad++; $display("FAIL reset gain: got %h want 0000", bus.gain); end
    total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL reset sat: got %b want 0", bus.sat); end
    rst = 1'b0;
  endtask

  task automatic test_exact();
    vec_t v[3];
    logic [15:0] g; logic s; int lat; bit ok;
    v[0] = '{8'd128, 8'd64,  16'h4000, 1'b0};
    v[1] = '{8'd1,   8'd3,   16'h0AAA, 1'b0};
    v[2] = '{8'd3,   8'd2,   16'h3000, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].n, v[i].d, 0, g, s, lat, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL exact[%0d] timeout: no result within bound", i); end
      else begin
        total++; if (g !== v[i].g) begin bad++; $display("FAIL exact[%0d] gain: got %h want %h", i, g, v[i].g); end
        total++; if (s !== v[i].s) begin bad++; $display("FAIL exact[%0d] sat: got %b want %b", i, s, v[i].s); end
        total++; if (lat != 18) begin bad++; $display("FAIL exact[%0d] latency: got %0d want 18", i, lat); end
      end
    end
  endtask

  task automatic test_saturation();
    vec_t v[4];
    logic [15:0] g; logic s; int lat; bit ok;
    v[0] = '{8'd255, 8'd32, 16'hFF00, 1'b0};
    v[1] = '{8'd255, 8'd31, 16'hFFFF, 1'b1};
    v[2] = '{8'd8,   8'd1,  16'hFFFF, 1'b1};
    v[3] = '{8'd7,   8'd1,  16'hE000, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].n, v[i].d, 0, g, s, lat, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL sat[%0d] timeout: no result within bound", i); end
      else begin
        total++; if (g !== v[i].g) begin bad++; $display("FAIL sat[%0d] gain: got %h want %h", i, g, v[i].g); end
        total++; if (s !== v[i].s) begin bad++; $display("FAIL sat[%0d] sat: got %b want %b", i, s, v[i].s); end
        total++; if (lat != 18) begin bad++; $display("FAIL sat[%0d] latency: got %0d want 18", i, lat); end
      end
    end
  endtask

  task automatic test_zero();
    vec_t v[2];
    logic [15:0] g; logic s; int lat; bit ok;
    v[0] = '{8'd5, 8'd0, 16'hFFFF, 1'b1};
    v[1] = '{8'd0, 8'd5, 16'h0000, 1'b0};
    for (int i = 0; i < 2; i++) begin
      do_op(v[i].n, v[i].d, 0, g, s, lat, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL zero[%0d] timeout: no result within bound", i); end
      else begin
        total++; if (g !== v[i].g) begin bad++; $display("FAIL zero[%0d] gain: got %h want %h", i, g, v[i].g); end
        total++; if (s !== v[i].s) begin bad++; $display("FAIL zero[%0d] sat: got %b want %b", i, s, v[i].s); end
        total++; if (lat != 18) begin bad++; $display("FAIL zero[%0d] latency: got %0d want 18", i, lat); end
      end
    end
  endtask

  task automatic test_backpressure();
    int c0;
    bit seen;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp idle in_ready: got %b want 1", bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.num = 8'd3;
    bus.den = 8'd2;
    c0 = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!seen || (cyc - c0) != 18) begin bad++; $display("FAIL bp latency: got %0d want 18 (seen=%0b)", cyc - c0, seen); end
    // Stall in DONE while offering a competing operand that must be ignored.
    bus.in_valid = 1'b1;
    bus.num = 8'd255;
    bus.den = 8'd1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.gain !== 16'h3000 || bus.sat !== 1'b0 || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp stall[%0d]: got ov=%b gain=%h sat=%b ir=%b want ov=1 gain=3000 sat=0 ir=0",
                 k, bus.out_valid, bus.gain, bus.sat, bus.in_ready);
      end
    end
    // Release, with the next operand already waiting.
    bus.num = 8'd1;
    bus.den = 8'd3;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp release out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp release in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.gain !== 16'h3000) begin bad++; $display("FAIL bp gain held: got %h want 3000", bus.gain); end
    c0 = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!seen || (cyc - c0) != 18) begin bad++; $display("FAIL bp next latency: got %0d want 18 (seen=%0b)", cyc - c0, seen); end
    total++; if (bus.gain !== 16'h0AAA || bus.sat !== 1'b0) begin bad++; $display("FAIL bp next result: got %h/%b want 0aaa/0", bus.gain, bus.sat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int nacc = 0;
    logic [15:0] g[2];
    logic s[2];
    int nres = 0;
    acc[0] = 0; acc[1] = 0;
    g[0] = '0; g[1] = '0; s[0] = 1'b0; s[1] = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.num = 8'd255;
    bus.den = 8'd32;
    for (int k = 0; k < 80 && nres < 2; k++) begin
      if (bus.in_valid && bus.in_ready && nacc < 2) begin acc[nacc] = cyc; nacc++; end
      if (bus.out_valid && bus.out_ready && nres < 2) begin g[nres] = bus.gain; s[nres] = bus.sat; nres++; end
      @(negedge clk);
      if (nacc == 1) begin bus.num = 8'd7; bus.den = 8'd1; end
      if (nacc == 2) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    total++; if (nres != 2 || nacc != 2) begin bad++; $display("FAIL b2b count: got acc=%0d res=%0d want 2/2", nacc, nres); end
    total++; if ((acc[1] - acc[0]) != 19) begin bad++; $display("FAIL b2b interval: got %0d want 19", acc[1] - acc[0]); end
    total++; if (g[0] !== 16'hFF00 || s[0] !== 1'b0) begin bad++; $display("FAIL b2b first: got %h/%b want ff00/0", g[0], s[0]); end
    total++; if (g[1] !== 16'hE000 || s[1] !== 1'b0) begin bad++; $display("FAIL b2b second: got %h/%b want e000/0", g[1], s[1]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] g; logic s; int lat; bit ok;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.num = 8'd77;
    bus.den = 8'd9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);  // now in cycle t+9, mid-division
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL rmid busy: got ov=%b ir=%b want 0/0", bus.out_valid, bus.in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rmid in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.gain !== 16'h0000 || bus.sat !== 1'b0) begin bad++; $display("FAIL rmid gain/sat: got %h/%b want 0000/0", bus.gain, bus.sat); end
    do_op(8'd200, 8'd100, 0, g, s, lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rmid after timeout: no result within bound"); end
    else begin
      total++; if (g !== 16'h4000 || s !== 1'b0) begin bad++; $display("FAIL rmid after result: got %h/%b want 4000/0", g, s); end
      total++; if (lat != 18) begin bad++; $display("FAIL rmid after latency: got %0d want 18", lat); end
    end
  endtask

  task automatic test_random();
    logic [7:0] n, d;
    logic [15:0] g, eg;
    logic s, es;
    int lat, q;
    bit ok;
    for (int i = 0; i < 500; i++) begin
      n = 8'($urandom_range(0, 255));
      d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (d == 0) begin
        eg = 16'hFFFF; es = 1'b1;
      end else begin
        q = (int'(n) * 8192) / int'(d);
        if (q > 65535) begin eg = 16'hFFFF; es = 1'b1; end
        else begin eg = 16'(q); es = 1'b0; end
      end
      do_op(n, d, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)), g, s, lat, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rand[%0d] timeout: num=%0d den=%0d", i, n, d); end
      else if (g !== eg || s !== es || lat != 18) begin
        bad++;
        $display("FAIL rand[%0d] num=%0d den=%0d: got %h/%b lat %0d want %h/%b lat 18", i, n, d, g, s, lat, eg, es);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exact();
    test_saturation();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
